// File: rtl/pipe_ctrl.sv
// Pipeline hazard, forwarding and halt controller for a 5-stage core.
// Owns stall/flush/freeze decisions, operand bypass select and stall count.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_use1,
    input  logic        id_use2,
    input  logic        id_halt,
    input  logic [3:0]  ex_dst,
    input  logic        ex_wr,
    input  logic        ex_load,
    input  logic [3:0]  mem_dst,
    input  logic        mem_wr,
    input  logic [3:0]  wb_dst,
    input  logic        wb_wr,
    input  logic        ex_redirect,
    input  logic        dm_busy,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        mem_wb_we,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        hlt,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_MWAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic load_use;

    // Write-back data reaches the register file directly; no WB bypass.
    logic unused_wb;
    assign unused_wb = ^{wb_dst, wb_wr};

    always_comb begin
        ex_hit1  = id_use1 && ex_wr && (ex_dst == id_rs1) && (ex_dst != 4'd0);
        ex_hit2  = id_use2 && ex_wr && (ex_dst == id_rs2) && (ex_dst != 4'd0);
        mem_hit1 = id_use1 && mem_wr && (mem_dst == id_rs1)
                   && (mem_dst != 4'd0);
        mem_hit2 = id_use2 && mem_wr && (mem_dst == id_rs2)
                   && (mem_dst != 4'd0);
        load_use = ex_load && (ex_hit1 || ex_hit2);
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (ex_hit1) begin
                fwd_a = 2'b01;
            end else if (mem_hit1) begin
                fwd_a = 2'b10;
            end
            if (ex_hit2) begin
                fwd_b = 2'b01;
            end else if (mem_hit2) begin
                fwd_b = 2'b10;
            end
        end
    end

    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_clear = 1'b0;
        id_ex_clear = 1'b0;
        hlt         = 1'b0;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;

        if (rst) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
            state_d     = S_RUN;
            drain_cnt_d = 2'd0;
        end else begin
            case (state_q)
                S_RUN, S_MWAIT: begin
                    if (dm_busy) begin
                        state_d = S_MWAIT;
                    end else begin
                        // MWAIT with memory done behaves exactly as RUN
                        state_d   = S_RUN;
                        id_ex_we  = 1'b1;
                        ex_mem_we = 1'b1;
                        mem_wb_we = 1'b1;
                        if (ex_redirect) begin
                            pc_we       = 1'b1;
                            if_id_we    = 1'b1;
                            if_id_clear = 1'b1;
                            id_ex_clear = 1'b1;
                        end else begin
                            if (load_use) begin
                                id_ex_clear = 1'b1;
                            end else begin
                                pc_we    = 1'b1;
                                if_id_we = 1'b1;
                            end
                            if (id_halt) begin
                                state_d     = S_DRAIN;
                                drain_cnt_d = 2'd3;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!dm_busy) begin
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        mem_wb_we   = 1'b1;
                        if_id_clear = 1'b1;
                        drain_cnt_d = drain_cnt_q - 2'd1;
                        if (drain_cnt_q == 2'd1) begin
                            state_d = S_HALTED;
                        end
                    end
                end
                S_HALTED: begin
                    hlt = 1'b1;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (state_q != S_HALTED) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            drain_cnt_q <= 2'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  id_rs1, id_rs2, ex_dst, mem_dst, wb_dst;
    logic        id_use1, id_use2, id_halt, ex_wr, ex_load;
    logic        mem_wr, wb_wr, ex_redirect, dm_busy;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_clear, id_ex_clear, hlt;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model state: halted flag, non-busy drain cycles left, stall count
    bit          m_halted;
    int          m_drain;
    int          m_stalls;
    logic [11:0] e_ctl;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_halt(id_halt),
        .ex_dst(ex_dst), .ex_wr(ex_wr), .ex_load(ex_load),
        .mem_dst(mem_dst), .mem_wr(mem_wr),
        .wb_dst(wb_dst), .wb_wr(wb_wr),
        .ex_redirect(ex_redirect), .dm_busy(dm_busy),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .hlt(hlt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] src_sel(input logic u, input logic [3:0] r);
        if (!u || r == 4'd0) return 2'b00;
        if (ex_wr && ex_dst == r) return 2'b01;
        if (mem_wr && mem_dst == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_out();
        logic [4:0] we;
        logic [1:0] clr, fa, fb;
        logic       h, lu;
        fa = src_sel(id_use1, id_rs1);
        fb = src_sel(id_use2, id_rs2);
        lu = ex_load && ex_wr && ex_dst != 4'd0 &&
             ((id_use1 && ex_dst == id_rs1) || (id_use2 && ex_dst == id_rs2));
        h  = 1'b0;
        if (rst) begin
            we = 5'b00000; clr = 2'b11; fa = 2'b00; fb = 2'b00;
        end else if (m_halted) begin
            we = 5'b00000; clr = 2'b00; h = 1'b1;
        end else if (dm_busy) begin
            we = 5'b00000; clr = 2'b00;
        end else if (m_drain > 0) begin
            we = 5'b00111; clr = 2'b10;
        end else if (ex_redirect) begin
            we = 5'b11111; clr = 2'b11;
        end else if (lu) begin
            we = 5'b00111; clr = 2'b01;
        end else begin
            we = 5'b11111; clr = 2'b00;
        end
        e_ctl = {we, clr, fa, fb, h};
    endtask

    task automatic model_update();
        if (rst) begin
            m_halted = 1'b0; m_drain = 0; m_stalls = 0;
        end else if (!m_halted) begin
            if (!e_ctl[11] && m_stalls < 65535) m_stalls++;
            if (dm_busy) begin
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) m_halted = 1'b1;
            end else if (!ex_redirect && id_halt) begin
                m_drain = 3;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Evaluate at the falling edge, then commit at the next rising edge
    task automatic eval(input string tag);
        model_out();
        @(negedge clk);
        check({tag, "_ctl"},
              {4'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_clear, id_ex_clear, fwd_a, fwd_b, hlt},
              {4'd0, e_ctl});
        check({tag, "_stall"}, stall_cnt, m_stalls[15:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input string tag);
        eval(tag);
        tick();
    endtask

    task automatic idle_in();
        rst = 1'b0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        id_halt = 0; ex_dst = 0; ex_wr = 0; ex_load = 0; mem_dst = 0;
        mem_wr = 0; wb_dst = 0; wb_wr = 0; ex_redirect = 0; dm_busy = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    task automatic load_use_in();
        idle_in();
        ex_load = 1; ex_wr = 1; ex_dst = 4'd3; id_rs1 = 4'd3; id_use1 = 1;
    endtask

    initial begin
        m_halted = 0; m_drain = 0; m_stalls = 0;
        idle_in();
        rst = 1'b1;
        eval("por");
        check("por_clears", {14'd0, if_id_clear, id_ex_clear}, 16'h0003);
        tick();
        rst = 1'b0;
        step("first_run");

        // load-use stall then MEM/WB forward
        load_use_in();
        eval("lu");
        check("lu_pc_we", {15'd0, pc_we}, 16'd0);
        check("lu_idex_clr", {15'd0, id_ex_clear}, 16'd1);
        tick();
        ex_dst = 0; mem_dst = 4'd3; mem_wr = 1;
        eval("lu_fwd");
        check("lu_fwd_a", {14'd0, fwd_a}, 16'd2);
        check("lu_cnt", stall_cnt, 16'd1);
        tick();

        // EX/MEM beats MEM/WB; R0 never forwards
        idle_in();
        ex_wr = 1; ex_dst = 5; mem_wr = 1; mem_dst = 5; id_rs2 = 5; id_use2 = 1;
        eval("prio");
        check("prio_fwd_b", {14'd0, fwd_b}, 16'd1);
        tick();
        ex_dst = 0; id_rs2 = 0; ex_load = 1;
        eval("r0");
        check("r0_fwd_b", {14'd0, fwd_b, pc_we}, 16'd1);
        tick();

        // redirect beats load-use and halt
        load_use_in();
        id_halt = 1; ex_redirect = 1;
        eval("redir");
        check("redir_flags", {13'd0, pc_we, if_id_clear, id_ex_clear}, 16'd7);
        tick();
        idle_in();
        step("redir_after");

        // busy over a load-use hazard
        do_reset();
        load_use_in();
        dm_busy = 1;
        repeat (4) step("busy");
        dm_busy = 0;
        step("busy_lu");
        idle_in();
        eval("busy_cnt");
        check("busy_cnt_val", stall_cnt, 16'd5);
        tick();

        // halt with one busy cycle inside drain
        do_reset();
        id_halt = 1;
        step("halt");
        idle_in();
        step("drain1");
        step("drain2");
        dm_busy = 1;
        step("drain_busy");
        dm_busy = 0;
        step("drain3");
        repeat (5) begin
            ex_redirect = 1'($urandom);
            dm_busy = 1'($urandom);
            eval("halted");
            check("halted_hlt", {15'd0, hlt}, 16'd1);
            tick();
        end
        idle_in();
        do_reset();
        eval("unhalt");
        check("unhalt_hlt", {15'd0, hlt}, 16'd0);
        tick();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            id_rs1      = 4'($urandom_range(0, 3));
            id_rs2      = 4'($urandom_range(0, 3));
            ex_dst      = 4'($urandom_range(0, 3));
            mem_dst     = 4'($urandom_range(0, 3));
            wb_dst      = 4'($urandom);
            id_use1     = 1'($urandom);
            id_use2     = 1'($urandom);
            ex_wr       = 1'($urandom);
            ex_load     = 1'($urandom);
            mem_wr      = 1'($urandom);
            wb_wr       = 1'($urandom);
            id_halt     = ($urandom_range(0, 19) == 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            dm_busy     = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        // stall counter saturation
        do_reset();
        dm_busy = 1;
        for (int i = 0; i < 65540; i++) begin
            model_out();
            tick();
        end
        eval("sat");
        check("sat_val", stall_cnt, 16'hFFFF);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
